// File: rtl/cmp_code_decoder.sv
// Decoder for the 6-bit magnitude-comparator result code. It accepts codes over valid/ready and
// gives a registered one-hot result, saturating tallies, and a lock after repeated illegal codes.
module cmp_code_decoder #(
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_lt,
  output logic             out_gt,
  output logic             out_eq,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr,
  output logic             locked,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {RUN = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [5:0]       CODE_LT   = 6'b010101;
  localparam logic [5:0]       CODE_GT   = 6'b011010;
  localparam logic [5:0]       CODE_EQ   = 6'b100011;
  localparam logic [3:0]       RUN_LIMIT = 4'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state;
  logic [3:0] err_run;
  logic [3:0] err_run_inc;
  logic       accept;
  logic       hit_lt;
  logic       hit_gt;
  logic       hit_eq;
  logic       hit_err;

  assign in_ready    = (state == RUN) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign hit_lt      = (in_code == CODE_LT);
  assign hit_gt      = (in_code == CODE_GT);
  assign hit_eq      = (in_code == CODE_EQ);
  assign hit_err     = !(hit_lt || hit_gt || hit_eq);
  assign err_run_inc = err_run + 4'd1;
  assign locked      = (state == LOCKED);

  // A clear wins over increment, but a same-cycle accept still counts as the first hit.
  function automatic logic [CNT_W-1:0] tally_next(input logic [CNT_W-1:0] cur,
                                                  input logic hit, input logic clear);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (clear)
      nxt = hit ? CNT_ONE : '0;
    else if (hit && (cur != CNT_MAX))
      nxt = cur + CNT_ONE;
    return nxt;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_lt    <= 1'b0;
      out_gt    <= 1'b0;
      out_eq    <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_lt    <= hit_lt;
      out_gt    <= hit_gt;
      out_eq    <= hit_eq;
      out_err   <= hit_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lt_cnt  <= '0;
      gt_cnt  <= '0;
      eq_cnt  <= '0;
      err_cnt <= '0;
      err_run <= 4'd0;
      state   <= RUN;
    end else begin
      lt_cnt  <= tally_next(lt_cnt,  accept && hit_lt,  clr);
      gt_cnt  <= tally_next(gt_cnt,  accept && hit_gt,  clr);
      eq_cnt  <= tally_next(eq_cnt,  accept && hit_eq,  clr);
      err_cnt <= tally_next(err_cnt, accept && hit_err, clr);
      if (clr) begin
        err_run <= (accept && hit_err) ? 4'd1 : 4'd0;
        state   <= RUN;
      end else if (accept) begin
        err_run <= hit_err ? err_run_inc : 4'd0;
        // The limit cannot be reached inside a clear cycle, so locking only happens here.
        if (hit_err && (err_run_inc == RUN_LIMIT))
          state <= LOCKED;
      end
    end
  end

endmodule

// File: tb/tb_cmp_code_decoder.sv
// Randomised, self-checking bench for cmp_code_decoder. Directed scenarios come first,
// followed by random traffic checked every cycle against a transaction-level model.
module tb_cmp_code_decoder;

  localparam int CNT_W     = 4;
  localparam int ERR_LIMIT = 3;
  localparam int MAX       = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       in_code;
  logic             in_valid;
  logic             in_ready;
  logic             out_lt, out_gt, out_eq, out_err;
  logic             out_valid;
  logic             out_ready;
  logic             clr;
  logic             locked;
  logic [CNT_W-1:0] lt_cnt, gt_cnt, eq_cnt, err_cnt;

  int tests = 0;
  int fails = 0;

  // Model state: pending result class and tallies indexed 0=lt 1=gt 2=eq 3=err
  bit m_valid  = 1'b0;
  int m_cls    = 0;
  int m_cnt[4] = '{0, 0, 0, 0};
  int m_run    = 0;
  bit m_locked = 1'b0;

  cmp_code_decoder #(.CNT_W(CNT_W), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready),
    .out_lt(out_lt), .out_gt(out_gt), .out_eq(out_eq), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .clr(clr), .locked(locked),
    .lt_cnt(lt_cnt), .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int classify(input logic [5:0] c);
    case (c)
      6'b010101: return 0;
      6'b011010: return 1;
      6'b100011: return 2;
      default:   return 3;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge and return just after the next one.
  task automatic applyStimulus(input bit v, input logic [5:0] code, input bit rdy, input bit c);
    in_valid  = v;
    in_code   = code;
    out_ready = rdy;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: one transaction step per rising edge.
  always @(posedge clk or posedge rst) begin
    bit acc;
    int cls;
    if (rst) begin
      m_valid  <= 1'b0;
      m_cls    <= 0;
      m_run    <= 0;
      m_locked <= 1'b0;
      for (int k = 0; k < 4; k++) m_cnt[k] <= 0;
    end else begin
      acc = in_valid && !m_locked && (!m_valid || out_ready);
      cls = classify(in_code);
      if (acc) begin
        m_valid <= 1'b1;
        m_cls   <= cls;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      if (clr) begin
        for (int k = 0; k < 4; k++) m_cnt[k] <= (acc && cls == k) ? 1 : 0;
        m_run    <= (acc && cls == 3) ? 1 : 0;
        m_locked <= 1'b0;
      end else if (acc) begin
        if (m_cnt[cls] < MAX) m_cnt[cls] <= m_cnt[cls] + 1;
        if (cls == 3) begin
          m_run <= m_run + 1;
          if (m_run + 1 == ERR_LIMIT) m_locked <= 1'b1;
        end else begin
          m_run <= 0;
        end
      end
    end
  end

  // Compare every cycle on the falling edge, away from input changes and clock edges.
  always @(negedge clk) begin
    checkOutput("in_ready", int'(in_ready), int'(!m_locked && (!m_valid || out_ready)));
    checkOutput("out_valid", int'(out_valid), int'(m_valid));
    checkOutput("locked", int'(locked), int'(m_locked));
    checkOutput("lt_cnt", int'(lt_cnt), m_cnt[0]);
    checkOutput("gt_cnt", int'(gt_cnt), m_cnt[1]);
    checkOutput("eq_cnt", int'(eq_cnt), m_cnt[2]);
    checkOutput("err_cnt", int'(err_cnt), m_cnt[3]);
    if (m_valid)
      checkOutput("result", int'({out_lt, out_gt, out_eq, out_err}), 8 >> m_cls);
    else if (rst)
      checkOutput("result_rst", int'({out_lt, out_gt, out_eq, out_err}), 0);
  end

  initial begin
    logic [5:0] err_seq [6];
    err_seq = '{6'b000000, 6'b111111, 6'b010101, 6'b000001, 6'b000010, 6'b000011};
    rst = 1'b1; in_valid = 1'b0; in_code = 6'd0; out_ready = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", int'(out_valid), 0);
    checkOutput("reset_locked", int'(locked), 0);
    rst = 1'b0;

    // Three legal codes back-to-back
    applyStimulus(1, 6'b010101, 1, 0);
    checkOutput("first_lt", int'({out_lt, out_gt, out_eq, out_err, out_valid}), 5'b10001);
    applyStimulus(1, 6'b011010, 1, 0);
    checkOutput("second_gt", int'({out_lt, out_gt, out_eq, out_err, out_valid}), 5'b01001);
    applyStimulus(1, 6'b100011, 1, 0);
    checkOutput("third_eq", int'({out_lt, out_gt, out_eq, out_err, out_valid}), 5'b00101);
    applyStimulus(0, 6'b000000, 1, 0);
    checkOutput("drained", int'(out_valid), 0);
    checkOutput("counts_111", int'({lt_cnt, gt_cnt, eq_cnt, err_cnt}), 16'h1110);

    // Back-pressure: result held, input stalled, then handoff and accept together
    applyStimulus(1, 6'b011010, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 6'b100011, 0, 0);
      checkOutput("hold_gt", int'({out_gt, out_valid, in_ready}), 3'b110);
    end
    applyStimulus(1, 6'b100011, 1, 0);
    checkOutput("handoff_eq", int'({out_eq, out_valid}), 2'b11);
    checkOutput("handoff_eq_cnt", int'(eq_cnt), 2);
    applyStimulus(0, 6'b000000, 1, 0);

    // Illegal-code run with a legal code in between
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, err_seq[i], 1, 0);
      if (i == 2) checkOutput("no_lock_after_legal", int'(locked), 0);
    end
    checkOutput("lock_set", int'({locked, in_ready}), 2'b10);
    checkOutput("last_err_out", int'({out_err, out_valid}), 2'b11);
    checkOutput("err_cnt_5", int'(err_cnt), 5);
    applyStimulus(1, 6'b010101, 1, 0);
    checkOutput("locked_ignores", int'(lt_cnt), 2);

    // Clear releases the lock
    applyStimulus(0, 6'b000000, 1, 1);
    checkOutput("clr_counts", int'({lt_cnt, gt_cnt, eq_cnt, err_cnt}), 0);
    checkOutput("clr_unlock", int'({locked, in_ready}), 2'b01);
    applyStimulus(1, 6'b100011, 1, 0);
    checkOutput("post_clr_eq", int'(eq_cnt), 1);

    // Saturation
    for (int i = 0; i < 20; i++) applyStimulus(1, 6'b010101, 1, 0);
    checkOutput("lt_saturate", int'(lt_cnt), MAX);

    // Clear coinciding with an illegal accept
    applyStimulus(1, 6'b111111, 1, 1);
    checkOutput("clr_accept", int'({lt_cnt, gt_cnt, eq_cnt, err_cnt}), 16'h0001);
    applyStimulus(1, 6'b010101, 0, 0);
    checkOutput("pending_before_rst", int'(out_valid), 1);

    // Asynchronous reset while a result is pending
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", int'(out_valid), 0);
    checkOutput("rst_async_outs", int'({out_lt, out_gt, out_eq, out_err}), 0);
    checkOutput("rst_async_cnt", int'(err_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [5:0] code;
      case ($urandom_range(0, 7))
        0, 1:    code = 6'b010101;
        2, 3:    code = 6'b011010;
        4, 5:    code = 6'b100011;
        default: code = 6'($urandom_range(0, 63));
      endcase
      applyStimulus(bit'($urandom_range(0, 3) != 0), code, bit'($urandom_range(0, 2) != 0),
                    bit'($urandom_range(0, 39) == 0));
    end
    applyStimulus(0, 6'b000000, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmp_code_decoder.md
Name: cmp_code_decoder

Overview:
- Receiving end of the 6-bit comparison-result code produced by the team's magnitude comparators: 010101 = A<B, 011010 = A>B, 100011 = A==B.
- Accepts codes on a valid/ready input and decodes each one to a registered one-hot result on a valid/ready output.
- Keeps saturating tallies per result class.
- Locks its input after ERR_LIMIT consecutive illegal codes until software clears it.

Parameters:
- CNT_W, 8, width of each tally counter.
- ERR_LIMIT, 3, consecutive illegal codes that trigger LOCKED. Legal range is 2 to 15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_code  input  6  comparison code
- in_valid  input  1  in_code is valid
- in_ready  output  1  decoder can accept a code this cycle
- out_lt  output  1  decoded A<B
- out_gt  output  1  decoded A>B
- out_eq  output  1  decoded A==B
- out_err  output  1  code was illegal
- out_valid  output  1  out_lt/gt/eq/err are valid
- out_ready  input  1  downstream accepts the result
- clr  input  1  synchronous clear of tallies, error run and lock
- locked  output  1  decoder is in LOCKED state
- lt_cnt, gt_cnt, eq_cnt, err_cnt  output  CNT_W each  saturating tallies

Behaviour:
- Reset (rst=1, asynchronous):
  - out_lt/gt/eq/err=0, out_valid=0, all counts=0, err_run=0, state=RUN, locked=0.
  - All are held while rst=1.
- in_ready is combinational: (state==RUN) && (!out_valid || out_ready).
- Accept occurs when in_valid && in_ready.
- Latency is one cycle. The cycle after an accept: out_valid=1 and exactly one of out_lt/gt/eq/err is 1.
  - Exact-match decode. Any of the other 61 values sets out_err.
- Output holding:
  - While out_valid && !out_ready, all out_* stay stable.
  - out_valid drops the cycle after out_ready=1 if no new accept occurred in that cycle.
  - Accept and output handoff in the same cycle gives back-to-back results at one per cycle.
- Tallies: the counter of the decoded class increments on each accept and saturates at 2^CNT_W-1 with no wrap.
- err_run (4-bit, internal):
  - Increments on accept of an illegal code.
  - Clears to 0 on accept of a legal code.
- FSM, two states:
  - RUN -> LOCKED on the accept that brings err_run to ERR_LIMIT. That code's out_err result is still delivered normally. locked=1 from the next cycle.
  - LOCKED: in_ready=0. The pending output still drains under out_ready.
  - LOCKED -> RUN on clr=1. locked=0 and in_ready may assert from the next cycle.
- clr (synchronous, priority over increment):
  - All counts and err_run load 0, except the class hit by a same-cycle accept, which loads 1. err_run loads 1 if that code is illegal.
  - No lock can occur in a clr cycle, because ERR_LIMIT>=2.
  - clr does not touch the output register or out_valid.
- Reset mid-transfer: a pending output is discarded and out_valid=0 immediately.
- in_code is ignored when it is not accepted.

Test Plan:
- Reset, then send 010101, 011010, 100011 with out_ready=1 -> outputs lt, gt, eq on consecutive cycles, each 1 cycle after accept. Counts end at 1/1/1, err_cnt=0.
- Send 011010 with out_ready=0 for 4 cycles -> out_gt and out_valid are stable, in_ready=0 while held. Then out_ready=1 -> next code accepted that same cycle.
- With ERR_LIMIT=3, send 000000, 111111, 010101, 000001, 000010, 000011 -> no lock after the legal code. LOCKED after the 6th code; locked=1 and in_ready=0 next cycle; err_cnt=5; last out_err still delivered.
- While LOCKED, pulse clr -> all counts=0, locked=0, in_ready=1 next cycle. Then 100011 -> eq_cnt=1.
- With CNT_W=4, send 20 codes of 010101 -> lt_cnt saturates at 15.
- clr in the same cycle as accepting 111111 -> err_cnt=1, other counts 0. Assert rst while out_valid=1 -> out_valid=0 immediately, all outputs 0.
